fifo_wr_arbiter: RTL

Round-robin arbiter that shares the single write port of the async FIFO (fifo_top) between NUM_REQ producers on the write-clock domain. It grants one requester at a time for a bounded burst, muxes that requester's data onto the FIFO push interface, and applies FIFO full back-pressure to the granted requester only. It sits between the producers and fifo_top's write side, and the tester_fifo push traffic drives it in benches.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO and its write-side arbiter.
//   DATA_WIDTH  : FIFO word width.
//   arb_state_e : write-arbiter FSM states (IDLE waits for a request,
//                 SERVE pushes words for the granted requester).
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

endpackage : fifo_pkg

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin priority search.
// Ports:
//   req_i        : request vector, one bit per requester.
//   last_grant_i : index granted last time; the search starts just above it
//                  and wraps modulo NUM_REQ.
//   idx_o        : first requesting index found by the search.
//   any_o        : high when at least one request bit is set.
// ----------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    // Walk the offsets from farthest to nearest so the nearest requester
    // (lowest offset above last_grant_i) is the one left in idx_o.
    always_comb begin
        int                 cand;
        logic [IDX_W-1:0]   cand_idx;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = (int'(last_grant_i) + off) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (req_i[cand_idx]) begin
                idx_o = cand_idx;
                any_o = 1'b1;
            end
        end
    end

endmodule : rr_pick

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin sharing of the FIFO write port between NUM_REQ producers.
// One requester is granted at a time for at most MAX_BURST words; its data
// is muxed onto the FIFO push interface and FIFO full stalls only it.
// Ports:
//   wr_clk, wr_rst : write clock, synchronous active-high reset.
//   req_valid      : per-requester word valid.
//   req_data       : packed words, requester i at [i*DATA_WIDTH +: DATA_WIDTH].
//   req_ready      : per-requester accept (transfer on valid && ready).
//   fifo_full      : FIFO full flag (acts combinationally).
//   fifo_push      : FIFO write enable.
//   fifo_wdata     : FIFO write data (zero outside SERVE).
//   grant_id       : current or last granted requester.
//   busy           : high while serving a grant.
// ----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter  int MAX_BURST  = 8,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_push,
    output logic [DATA_WIDTH-1:0]         fifo_wdata,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
);

    import fifo_pkg::*;

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   last_q,  last_d;
    logic [CNT_W-1:0]   burst_q, burst_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  serving;
    logic                  push;
    logic [DATA_WIDTH-1:0] word_arr [NUM_REQ];

    // Unpack the requester words so the data mux is a plain array index.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign word_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .idx_o        (pick_idx),
        .any_o        (pick_any)
    );

    // Reset gates the outputs so an abandoned burst cannot push on the
    // reset cycle even though state_q still reads SERVE until the edge.
    assign serving    = (state_q == SERVE) && !wr_rst;
    assign push       = serving && req_valid[grant_q] && !fifo_full;
    assign fifo_push  = push;
    assign fifo_wdata = serving ? word_arr[grant_q] : '0;
    assign busy       = serving;
    assign grant_id   = grant_q;

    always_comb begin
        req_ready = '0;
        if (serving && !fifo_full) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = SERVE;
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    burst_d = '0;
                end
            end
            SERVE: begin
                if (push) begin
                    burst_d = burst_q + 1'b1;
                    if (burst_q == LAST_BEAT) begin
                        state_d = IDLE;
                    end
                end else if (!req_valid[grant_q]) begin
                    // Requester yielded; a full stall keeps the grant.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end

endmodule : fifo_wr_arbiter
